// File: rtl/car_pkg.sv
// Shared definitions for the car speed controller and its downstream consumers.
// - Speed codes as produced by the controller on its 2-bit speed output.
// - State encoding of the overspeed alarm FSM.
package car_pkg;

  localparam logic [1:0] SPD_STOP = 2'b00;
  localparam logic [1:0] SPD_LOW  = 2'b01;
  localparam logic [1:0] SPD_MED  = 2'b10;
  localparam logic [1:0] SPD_HIGH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_ALARM = 2'b10
  } alarm_state_e;

endpackage

// File: rtl/car_speed_odometer_overspeed_monitor.sv
// overspeed_monitor: raises overspeed once HIGH speed (with ignition on) has
// been seen for ALARM_CYCLES consecutive rising edges, and drops it on the
// first edge where that no longer holds.
// Ports:
//   clock     system clock
//   reset     synchronous, active-high
//   keys      ignition (0 = engine off)
//   speed     speed code from the controller
//   overspeed registered alarm flag (state == ST_ALARM)
module overspeed_monitor
  import car_pkg::*;
#(
  parameter int ALARM_CYCLES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       keys,
  input  logic [1:0] speed,
  output logic       overspeed
);

  localparam int             HW   = $clog2(ALARM_CYCLES + 1);
  localparam logic [HW-1:0]  HMAX = HW'(ALARM_CYCLES);

  alarm_state_e  state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          high;

  // Ignition off counts as "not HIGH", so keys falling always returns to IDLE.
  assign high = keys && (speed == SPD_HIGH);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (high) begin
          if (ALARM_CYCLES == 1) begin
            state_d = ST_ALARM;
            hcnt_d  = HMAX;
          end else begin
            state_d = ST_COUNT;
            hcnt_d  = HW'(1);
          end
        end else begin
          hcnt_d = '0;
        end
      end
      ST_COUNT: begin
        if (high) begin
          hcnt_d = hcnt_q + HW'(1);
          if (hcnt_d == HMAX) state_d = ST_ALARM;
        end else begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end
      end
      ST_ALARM: begin
        // hcnt stays saturated at HMAX while the alarm holds.
        if (!high) begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge; reset is checked inside the clocked
  // block, making it synchronous.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign overspeed = (state_q == ST_ALARM);

endmodule

// File: rtl/car_speed_odometer.sv
// car_speed_odometer: integrates the controller's speed code into distance.
// A speed-weighted accumulator produces one unit_tick per TICKS_PER_UNIT
// weighted cycles; ticks advance a wrapping odometer and a saturating,
// clearable trip counter. The overspeed alarm lives in overspeed_monitor.
// Ports:
//   clock      system clock
//   reset      synchronous, active-high; clears all state
//   keys       ignition (0 = engine off, no distance accrues)
//   speed      speed code 00 STOP .. 11 HIGH, used as increment 0..3
//   trip_clear clears trip; wins over a simultaneous tick
//   odometer   total distance units, wraps
//   trip       units since last trip_clear, saturates at all-ones
//   unit_tick  one-cycle pulse per completed unit
//   overspeed  HIGH held for >= ALARM_CYCLES cycles
//   moving     registered (keys && speed != STOP)
module car_speed_odometer
  import car_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 4,
  parameter int DIST_W         = 16,
  parameter int TRIP_W         = 12,
  parameter int ALARM_CYCLES   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              keys,
  input  logic [1:0]        speed,
  input  logic              trip_clear,
  output logic [DIST_W-1:0] odometer,
  output logic [TRIP_W-1:0] trip,
  output logic              unit_tick,
  output logic              overspeed,
  output logic              moving
);

  // acc never exceeds TICKS_PER_UNIT-1, so acc + 3 fits in AW bits without
  // needing a carry bit.
  localparam int            AW  = $clog2(TICKS_PER_UNIT + 3);
  localparam logic [AW-1:0] TPU = AW'(TICKS_PER_UNIT);

  logic [AW-1:0] acc, inc, sum, acc_next;
  logic          tick;

  always_comb begin
    inc      = keys ? AW'(speed) : '0;
    sum      = acc + inc;
    tick     = (sum >= TPU);
    // inc <= 3 < TICKS_PER_UNIT, so one subtraction is always enough.
    acc_next = tick ? (sum - TPU) : sum;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      odometer  <= '0;
      trip      <= '0;
      unit_tick <= 1'b0;
      moving    <= 1'b0;
    end else begin
      acc       <= acc_next;
      unit_tick <= tick;
      moving    <= keys && (speed != SPD_STOP);
      if (tick) odometer <= odometer + DIST_W'(1);
      if (trip_clear)                trip <= '0;
      else if (tick && (trip != '1)) trip <= trip + TRIP_W'(1);
    end
  end

  overspeed_monitor #(
    .ALARM_CYCLES(ALARM_CYCLES)
  ) u_monitor (
    .clock    (clock),
    .reset    (reset),
    .keys     (keys),
    .speed    (speed),
    .overspeed(overspeed)
  );

endmodule

// File: tb/tb_car_speed_odometer.sv
// Self-checking bench for car_speed_odometer. Two instances share stimulus:
// dut uses default widths, dut_s uses DIST_W=4/TRIP_W=3 to reach wrap and
// saturation quickly. A behavioural model pushes expected outputs into a
// queue on every driven cycle; they are popped and compared after the edge.
module tb_car_speed_odometer;

  localparam int TPU = 4;
  localparam int AC  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        keys = 1'b0;
  logic [1:0]  speed = 2'b00;
  logic        trip_clear = 1'b0;

  logic [15:0] odometer;
  logic [11:0] trip;
  logic        unit_tick, overspeed, moving;
  logic [3:0]  odometer_s;
  logic [2:0]  trip_s;
  logic        unit_tick_s, overspeed_s, moving_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  car_speed_odometer #(
    .TICKS_PER_UNIT(TPU), .DIST_W(16), .TRIP_W(12), .ALARM_CYCLES(AC)
  ) dut (
    .clock(clock), .reset(reset), .keys(keys), .speed(speed),
    .trip_clear(trip_clear), .odometer(odometer), .trip(trip),
    .unit_tick(unit_tick), .overspeed(overspeed), .moving(moving)
  );

  car_speed_odometer #(
    .TICKS_PER_UNIT(TPU), .DIST_W(4), .TRIP_W(3), .ALARM_CYCLES(AC)
  ) dut_s (
    .clock(clock), .reset(reset), .keys(keys), .speed(speed),
    .trip_clear(trip_clear), .odometer(odometer_s), .trip(trip_s),
    .unit_tick(unit_tick_s), .overspeed(overspeed_s), .moving(moving_s)
  );

  typedef struct {
    int   odo;
    int   trp;
    int   odo_s;
    int   trp_s;
    logic tick;
    logic ov;
    logic mov;
  } exp_t;

  exp_t sb[$];

  // Model state
  int m_acc = 0, m_odo = 0, m_trip = 0, m_odo_s = 0, m_trip_s = 0, m_run = 0;

  task automatic step(input logic k, input logic [1:0] s, input logic tc, input logic r);
    exp_t e;
    exp_t g;
    int   inc, sum;
    logic tk;
    @(negedge clock);
    keys = k; speed = s; trip_clear = tc; reset = r;
    tk = 1'b0;
    if (r) begin
      m_acc = 0; m_odo = 0; m_trip = 0; m_odo_s = 0; m_trip_s = 0; m_run = 0;
    end else begin
      inc = k ? int'(s) : 0;
      sum = m_acc + inc;
      tk  = (sum >= TPU);
      m_acc = tk ? sum - TPU : sum;
      if (tk) begin
        m_odo   = (m_odo + 1) % 65536;
        m_odo_s = (m_odo_s + 1) % 16;
      end
      if (tc) begin
        m_trip = 0; m_trip_s = 0;
      end else if (tk) begin
        if (m_trip < 4095) m_trip++;
        if (m_trip_s < 7)  m_trip_s++;
      end
      if (k && s == 2'b11) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else                 m_run = 0;
    end
    e.odo = m_odo; e.trp = m_trip; e.odo_s = m_odo_s; e.trp_s = m_trip_s;
    e.tick = tk; e.ov = (m_run >= AC); e.mov = !r && k && (s != 2'b00);
    sb.push_back(e);
    @(posedge clock);
    #1;
    cyc++;
    g = sb.pop_front();
    n_checks += 8;
    if (odometer !== 16'(g.odo)) begin
      n_fail++; $display("FAIL sb_odometer cyc %0d: got %0d expected %0d", cyc, odometer, g.odo);
    end
    if (trip !== 12'(g.trp)) begin
      n_fail++; $display("FAIL sb_trip cyc %0d: got %0d expected %0d", cyc, trip, g.trp);
    end
    if (unit_tick !== g.tick) begin
      n_fail++; $display("FAIL sb_unit_tick cyc %0d: got %b expected %b", cyc, unit_tick, g.tick);
    end
    if (overspeed !== g.ov) begin
      n_fail++; $display("FAIL sb_overspeed cyc %0d: got %b expected %b", cyc, overspeed, g.ov);
    end
    if (moving !== g.mov) begin
      n_fail++; $display("FAIL sb_moving cyc %0d: got %b expected %b", cyc, moving, g.mov);
    end
    if (odometer_s !== 4'(g.odo_s)) begin
      n_fail++; $display("FAIL sb_odometer_s cyc %0d: got %0d expected %0d", cyc, odometer_s, g.odo_s);
    end
    if (trip_s !== 3'(g.trp_s)) begin
      n_fail++; $display("FAIL sb_trip_s cyc %0d: got %0d expected %0d", cyc, trip_s, g.trp_s);
    end
    if (unit_tick_s !== g.tick) begin
      n_fail++; $display("FAIL sb_unit_tick_s cyc %0d: got %b expected %b", cyc, unit_tick_s, g.tick);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b1, 2'b11, 1'b0, 1'b1);
    n_checks++;
    if ({odometer, trip, unit_tick, overspeed, moving} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got odo=%0d trip=%0d tick=%b ov=%b mov=%b expected all 0",
               odometer, trip, unit_tick, overspeed, moving);
    end
  endtask

  task automatic test_low_speed();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 2'b01, 1'b0, 1'b0);
      n_checks++;
      if (unit_tick !== ((i == 4) || (i == 8))) begin
        n_fail++; $display("FAIL low_tick cycle %0d: got %b expected %b", i, unit_tick, (i == 4) || (i == 8));
      end
    end
    n_checks++;
    if (odometer !== 16'd2 || trip !== 12'd2 || overspeed !== 1'b0 || moving !== 1'b1) begin
      n_fail++;
      $display("FAIL low_totals: got odo=%0d trip=%0d ov=%b mov=%b expected 2 2 0 1",
               odometer, trip, overspeed, moving);
    end
  endtask

  task automatic test_high_speed();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 2'b11, 1'b0, 1'b0);
      n_checks += 2;
      if (unit_tick !== (i >= 2)) begin
        n_fail++; $display("FAIL high_tick cycle %0d: got %b expected %b", i, unit_tick, i >= 2);
      end
      if (overspeed !== (i >= 3)) begin
        n_fail++; $display("FAIL high_overspeed cycle %0d: got %b expected %b", i, overspeed, i >= 3);
      end
    end
    n_checks++;
    if (odometer !== 16'd5) begin
      n_fail++; $display("FAIL high_odometer: got %0d expected 5", odometer);
    end
    step(1'b1, 2'b10, 1'b0, 1'b0);
    n_checks++;
    if (overspeed !== 1'b0) begin
      n_fail++; $display("FAIL overspeed_release: got %b expected 0", overspeed);
    end
  endtask

  task automatic test_trip_clear();
    n_checks++;
    if (odometer !== 16'd5 || trip !== 12'd5) begin
      n_fail++; $display("FAIL clear_precond: got odo=%0d trip=%0d expected 5 5", odometer, trip);
    end
    // acc = 2 here; MEDIUM completes a unit on the same edge as the clear.
    step(1'b1, 2'b10, 1'b1, 1'b0);
    n_checks++;
    if (odometer !== 16'd6 || trip !== 12'd0 || unit_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_with_tick: got odo=%0d trip=%0d tick=%b expected 6 0 1", odometer, trip, unit_tick);
    end
  endtask

  task automatic test_keys_off();
    step(1'b1, 2'b01, 1'b0, 1'b0);  // acc = 1
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 2'b11, 1'b0, 1'b0);
      n_checks++;
      if (unit_tick !== 1'b0 || overspeed !== 1'b0 || moving !== 1'b0 || odometer !== 16'd6) begin
        n_fail++;
        $display("FAIL keys_off cycle %0d: got tick=%b ov=%b mov=%b odo=%0d expected 0 0 0 6",
                 i, unit_tick, overspeed, moving, odometer);
      end
    end
    // Held acc = 1, so 1 + 3 completes a unit immediately.
    step(1'b1, 2'b11, 1'b0, 1'b0);
    n_checks++;
    if (unit_tick !== 1'b1 || odometer !== 16'd7) begin
      n_fail++; $display("FAIL keys_resume: got tick=%b odo=%0d expected 1 7", unit_tick, odometer);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)  step(1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
    n_checks++;
    if (odometer !== 16'd9 || overspeed !== 1'b1) begin
      n_fail++; $display("FAIL mid_precond: got odo=%0d ov=%b expected 9 1", odometer, overspeed);
    end
    step(1'b1, 2'b11, 1'b0, 1'b1);
    n_checks++;
    if ({odometer, trip, unit_tick, overspeed, moving} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got odo=%0d trip=%0d tick=%b ov=%b mov=%b expected all 0",
               odometer, trip, unit_tick, overspeed, moving);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 2'b01, 1'b0, 1'b0);
      n_checks++;
      if (unit_tick !== (i == 4)) begin
        n_fail++; $display("FAIL post_reset_tick cycle %0d: got %b expected %b", i, unit_tick, i == 4);
      end
    end
  endtask

  task automatic test_wrap();
    int units;
    step(1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 2'b01, 1'b0, 1'b0);
      units = i / 4;
      n_checks++;
      if (trip_s !== 3'((units > 7) ? 7 : units)) begin
        n_fail++; $display("FAIL trip_saturate cycle %0d: got %0d expected %0d", i, trip_s, (units > 7) ? 7 : units);
      end
    end
    n_checks++;
    if (odometer_s !== 4'd0 || trip_s !== 3'd7 || odometer !== 16'd16) begin
      n_fail++;
      $display("FAIL wrap_end: got odo_s=%0d trip_s=%0d odo=%0d expected 0 7 16", odometer_s, trip_s, odometer);
    end
  endtask

  task automatic test_back_to_back();
    logic       k, tc, r;
    logic [1:0] s;
    for (int i = 0; i < 400; i++) begin
      k  = ($urandom_range(7) != 0);
      s  = 2'($urandom_range(3));
      tc = ($urandom_range(15) == 0);
      r  = ($urandom_range(63) == 0);
      step(k, s, tc, r);
    end
  endtask

  initial begin
    test_reset();
    test_low_speed();
    test_high_speed();
    test_trip_clear();
    test_keys_off();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
